// File: rtl/bayes_sram_loader.sv
// bayes_sram_loader
//   Programs the Bayesian probability SRAM from a valid/ready word stream. Words are written
//   to addresses 0..NUM_WORDS-1 in arrival order while a running XOR checksum is kept. With
//   VERIFY=1 the array is then read back, XOR-folded and compared against that checksum.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   start            one-cycle load request, honoured only when idle
//   in_valid/in_data word stream; in_ready is high while loading
//   mem_we/mem_re    SRAM write / read strobes (registered)
//   mem_addr         SRAM address for either strobe
//   mem_wdata        SRAM write data
//   mem_rdata        SRAM read data, valid the cycle after mem_re
//   busy             load or verify in progress
//   done             one-cycle pulse once the load has finished
//   error            sticky readback mismatch, cleared by the next accepted start
//   checksum         XOR of the words accepted in the current/last load
module bayes_sram_loader #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned ADDR_W    = 2,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WORD_SIZE-1:0] checksum
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StVerify,
    StCheck,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_WORDS - 1);

  state_e state_q, state_d;

  // cnt is the write index while loading and the read index while verifying.
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] rb_q, rb_d;
  logic [WORD_SIZE-1:0] checksum_q, checksum_d;
  logic                 error_q, error_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic xfer;

  assign in_ready = (state_q == StLoad);
  assign xfer     = in_valid && in_ready;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rb_q        <= '0;
      checksum_q  <= '0;
      error_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rb_q        <= rb_d;
      checksum_q  <= checksum_d;
      error_q     <= error_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   if (xfer && (cnt_q == LastIdx)) state_d = VERIFY ? StWait : StDone;
      StWait:   state_d = StVerify;
      StVerify: if (cnt_q == LastIdx) state_d = StCheck;
      StCheck:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d       = cnt_q;
    rb_d        = rb_q;
    checksum_d  = checksum_q;
    error_d     = error_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = state_d inside {StLoad, StWait, StVerify, StCheck};
    // done trails the DONE state by one cycle so it is seen with all results settled.
    done_d      = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d      = '0;
          checksum_d = '0;
          error_d    = 1'b0;
        end
      end
      StLoad: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = in_data;
          checksum_d  = checksum_q ^ in_data;
          cnt_d       = cnt_q + ADDR_W'(1);
        end
      end
      StWait: begin
        // The last write is on the bus now; first read goes out next cycle.
        mem_re_d   = 1'b1;
        mem_addr_d = '0;
        cnt_d      = '0;
        rb_d       = '0;
      end
      StVerify: begin
        // Data for the previous read arrives now; nothing to fold on the first read cycle.
        if (cnt_q != '0) rb_d = rb_q ^ mem_rdata;
        if (cnt_q != LastIdx) begin
          mem_re_d   = 1'b1;
          mem_addr_d = cnt_q + ADDR_W'(1);
          cnt_d      = cnt_q + ADDR_W'(1);
        end
      end
      StCheck: begin
        rb_d    = rb_q ^ mem_rdata;
        error_d = ((rb_q ^ mem_rdata) != checksum_q);
      end
      default: ;
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_bayes_sram_loader.sv
// Testbench for bayes_sram_loader: a timeline model predicts every output of the VERIFY=1
// instance each cycle; a VERIFY=0 instance is checked with directed expectations.
module tb_bayes_sram_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_we, mem_re, busy, done, error;
  logic [1:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, checksum;

  logic       start0, in_valid0;
  logic [7:0] in_data0;
  logic       in_ready0, mem_we0, mem_re0, busy0, done0, error0;
  logic [1:0] mem_addr0;
  logic [7:0] mem_wdata0, checksum0;
  logic [7:0] mem_rdata0 = 8'h00;

  always #5 clk = ~clk;

  bayes_sram_loader #(.WORD_SIZE(8), .NUM_WORDS(4), .ADDR_W(2), .VERIFY(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  bayes_sram_loader #(.WORD_SIZE(8), .NUM_WORDS(4), .ADDR_W(2), .VERIFY(1'b0)) u_nv (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(in_valid0), .in_data(in_data0),
    .in_ready(in_ready0), .mem_we(mem_we0), .mem_re(mem_re0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0), .done(done0),
    .error(error0), .checksum(checksum0)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // SRAM model; 'fault' corrupts readback of address 2.
  logic       fault = 1'b0;
  logic [7:0] sram [4];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? ((fault && mem_addr == 2'd2) ? 8'h5B : sram[mem_addr]) : 8'h00;
  end

  // Timeline model: at each edge, decide what the DUT must show in later cycles.
  bit         m_active = 1'b0;
  bit         m_load = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_chk = 8'h00;
  logic       m_err = 1'b0;
  logic       m_err_pend = 1'b0;
  int         m_done_cyc = -1;
  int         m_rd_start = -1;
  logic [7:0] m_words [4];
  logic [7:0] m_rb;
  int         m_cur;
  int         wq_c [256];
  logic [1:0] wq_a [256];
  logic [7:0] wq_d [256];
  int         m_wr_ptr = 0;
  int         m_flush = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   = 1'b0;
      m_load     = 1'b0;
      m_cnt      = 0;
      m_chk      = 8'h00;
      m_err      = 1'b0;
      m_done_cyc = -1;
      m_rd_start = -1;
      m_flush    = m_wr_ptr;
    end else begin
      m_cur = cyc;
      if (m_active && m_done_cyc >= 0 && m_cur == m_done_cyc - 1) begin
        m_active = 1'b0;
      end else if (!m_active && start) begin
        m_active   = 1'b1;
        m_load     = 1'b1;
        m_cnt      = 0;
        m_chk      = 8'h00;
        m_err      = 1'b0;
        m_done_cyc = -1;
        m_rd_start = -1;
      end else if (m_load && in_valid) begin
        wq_c[m_wr_ptr & 255] = m_cur + 1;
        wq_a[m_wr_ptr & 255] = m_cnt[1:0];
        wq_d[m_wr_ptr & 255] = in_data;
        m_wr_ptr++;
        m_words[m_cnt] = in_data;
        m_chk ^= in_data;
        m_cnt++;
        if (m_cnt == 4) begin
          // Last word: one write cycle, four reads, one check cycle, DONE, then the pulse.
          m_load     = 1'b0;
          m_rd_start = m_cur + 2;
          m_done_cyc = m_cur + 8;
          m_rb = 8'h00;
          for (int k = 0; k < 4; k++) m_rb ^= (fault && k == 2) ? 8'h5B : m_words[k];
          m_err_pend = (m_rb != m_chk);
        end
      end
      if (m_done_cyc >= 0 && m_cur + 1 == m_done_cyc - 1) m_err = m_err_pend;
    end
  end

  // Compare process for the VERIFY=1 instance.
  int rd_ptr = 0;
  bit exp_we, exp_re;
  always @(negedge clk) begin
    if (rd_ptr < m_flush) rd_ptr = m_flush;
    exp_we = (rd_ptr < m_wr_ptr) && (wq_c[rd_ptr & 255] == cyc);
    exp_re = (m_rd_start >= 0) && (cyc >= m_rd_start) && (cyc < m_rd_start + 4);
    check("in_ready", 32'(in_ready), 32'(m_load));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check("wr_addr", 32'(mem_addr), 32'(wq_a[rd_ptr & 255]));
      check("wr_data", 32'(mem_wdata), 32'(wq_d[rd_ptr & 255]));
      rd_ptr++;
    end
    check("mem_re", 32'(mem_re), 32'(exp_re));
    if (exp_re) check("rd_addr", 32'(mem_addr), 32'(cyc - m_rd_start));
    check("busy", 32'(busy),
          32'(m_active && (m_done_cyc < 0 || cyc < m_done_cyc - 1)));
    check("done", 32'(done), 32'(cyc == m_done_cyc));
    check("error", 32'(error), 32'(m_err));
    check("checksum", 32'(checksum), 32'(m_chk));
  end

  // Event counters used by the directed checks.
  int we_cnt = 0, re_cnt = 0, done_cnt = 0, we0_cnt = 0, re0_cnt = 0, done0_cnt = 0;
  logic [9:0] wlog [256];
  always @(negedge clk) begin
    if (mem_we) begin
      wlog[we_cnt & 255] = {mem_addr, mem_wdata};
      we_cnt++;
    end
    if (mem_re) re_cnt++;
    if (done) done_cnt++;
    if (mem_we0) we0_cnt++;
    if (mem_re0) re0_cnt++;
    if (done0) done0_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  int         s, at, last, we_b, re_b, done_b;
  logic [6:0] pat;
  logic [9:0] exp_w [4];

  initial begin
    start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    start0 = 1'b0; in_valid0 = 1'b0; in_data0 = 8'h00;
    exp_w[0] = 10'h0A5; exp_w[1] = 10'h1CC; exp_w[2] = 10'h25A; exp_w[3] = 10'h3F0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_flags", 32'({in_ready, mem_we, mem_re, busy, done, error}), 32'd0);
    check("rst_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Clean load with readback.
    we_b = we_cnt; re_b = re_cnt;
    s = cyc;
    do_start();
    send(8'hA5); send(8'hCC); send(8'h5A); send(8'hF0);
    wait_done(at);
    check("t1_latency", 32'(at - s), 32'd12);
    check("t1_checksum", 32'(checksum), 32'hC3);
    check("t1_error", 32'(error), 32'd0);
    check("t1_writes", 32'(we_cnt - we_b), 32'd4);
    check("t1_reads", 32'(re_cnt - re_b), 32'd4);
    if (we_cnt - we_b == 4)
      for (int i = 0; i < 4; i++) check("t1_wlog", 32'(wlog[(we_b + i) & 255]), 32'(exp_w[i]));
    tick();

    // Corrupted readback at address 2.
    fault = 1'b1;
    s = cyc;
    do_start();
    send(8'hA5); send(8'hCC); send(8'h5A); send(8'hF0);
    wait_done(at);
    check("t2_latency", 32'(at - s), 32'd12);
    check("t2_error", 32'(error), 32'd1);
    check("t2_checksum", 32'(checksum), 32'hC3);
    fault = 1'b0;
    tick();
    check("t2_error_held", 32'(error), 32'd1);

    // Gapped stream with stray starts during LOAD and VERIFY.
    s = cyc;
    do_start();
    check("t3_error_cleared", 32'(error), 32'd0);
    we_b = we_cnt; done_b = done_cnt;
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = 8'h30 + 8'(i) * 8'h11;
      start    = (i == 1);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("t3_ready_after_last", 32'(in_ready), 32'd0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(at);
    check("t3_latency", 32'(at - s), 32'd15);
    check("t3_checksum", 32'(checksum), 32'h40);
    repeat (4) tick();
    check("t3_writes", 32'(we_cnt - we_b), 32'd4);
    check("t3_single_done", 32'(done_cnt - done_b), 32'd1);

    // Reset after two accepted words.
    do_start();
    send(8'h11); send(8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_flags", 32'({in_ready, mem_we, mem_re, busy, done, error}), 32'd0);
    check("t4_rst_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
    check("t4_rst_checksum", 32'(checksum), 32'd0);
    done_b = done_cnt;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    check("t4_no_done", 32'(done_cnt - done_b), 32'd0);
    s = cyc;
    do_start();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    wait_done(at);
    check("t4_latency", 32'(at - s), 32'd12);
    check("t4_checksum", 32'(checksum), 32'h44);
    check("t4_error", 32'(error), 32'd0);
    tick();

    // VERIFY=0 instance: no reads, done two cycles after the last transfer.
    we_b = we0_cnt; re_b = re0_cnt; done_b = done0_cnt;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1;
      in_data0  = 8'h01 << i;
      last = cyc;
      tick();
    end
    in_valid0 = 1'b0;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      if (done0) begin
        at = cyc;
        break;
      end
      tick();
    end
    check("t5_done_delay", 32'(at - last), 32'd2);
    check("t5_checksum", 32'(checksum0), 32'h0F);
    check("t5_error", 32'(error0), 32'd0);
    repeat (3) tick();
    check("t5_writes", 32'(we0_cnt - we_b), 32'd4);
    check("t5_no_reads", 32'(re0_cnt - re_b), 32'd0);
    check("t5_single_done", 32'(done0_cnt - done_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
